// File: rtl/dense_pkg.sv
// Shared constants and types for the dense classifier result sink.
// Holds default widths, the scan FSM state enum and the class-index width helper.
package dense_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_CLASS  = 7;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Width of a class index; never below one bit.
    function automatic int cls_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dense_argmax_cmp.sv
// Strict greater-than comparator for one pair of class scores.
// Ports: a, b (scores), gt (a > b, signed or unsigned per SIGNED).
module dense_argmax_cmp
    import dense_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit SIGNED     = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  gt
);

    generate
        if (SIGNED) begin : g_signed
            assign gt = $signed(a) > $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
        end
    endgenerate

endmodule

// File: rtl/dense_argmax_rx.sv
// Serial argmax over a packed score vector with a one-deep pending slot.
// Ports: clk, rstn, data_i/valid_i in; class_o, max_o, valid_o, busy_o, pend_o, drop_o out.
module dense_argmax_rx
    import dense_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CLASS  = DEF_NUM_CLASS,
    parameter bit SIGNED     = 1'b1,
    parameter int CLS_W      = cls_w(NUM_CLASS)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [DATA_WIDTH*NUM_CLASS-1:0]  data_i,
    input  logic                             valid_i,
    output logic [CLS_W-1:0]                 class_o,
    output logic [DATA_WIDTH-1:0]            max_o,
    output logic                             valid_o,
    output logic                             busy_o,
    output logic                             pend_o,
    output logic                             drop_o
);

    typedef logic [NUM_CLASS-1:0][DATA_WIDTH-1:0] vec_t;

    localparam logic [CLS_W-1:0] LAST  = CLS_W'(NUM_CLASS - 1);
    localparam logic [CLS_W-1:0] FIRST = CLS_W'(1);

    state_t                state_q, state_d;
    vec_t                  work_q, work_d;
    vec_t                  pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [CLS_W-1:0]      cnt_q, cnt_d;
    logic [CLS_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] best_q, best_d;
    logic [CLS_W-1:0]      class_q, class_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic                  valid_q, valid_d;
    logic                  drop_q, drop_d;

    logic [DATA_WIDTH-1:0] elem;
    logic [DATA_WIDTH-1:0] best_nxt;
    logic [CLS_W-1:0]      idx_nxt;
    logic                  gt;
    logic                  last;
    logic                  load;
    vec_t                  load_vec;

    assign elem = work_q[cnt_q];

    dense_argmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED     (SIGNED)
    ) u_cmp (
        .a  (elem),
        .b  (best_q),
        .gt (gt)
    );

    // Strict compare keeps the earlier index on ties.
    assign best_nxt = gt ? elem  : best_q;
    assign idx_nxt  = gt ? cnt_q : idx_q;
    assign last     = (state_q == SCAN) && (cnt_q == LAST);

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        best_d      = best_q;
        class_d     = class_q;
        max_d       = max_q;
        valid_d     = 1'b0;
        drop_d      = 1'b0;
        load        = 1'b0;
        load_vec    = vec_t'(data_i);

        unique case (state_q)
            IDLE: begin
                load = valid_i;
            end
            SCAN: begin
                if (last) begin
                    valid_d = 1'b1;
                    class_d = idx_nxt;
                    max_d   = best_nxt;
                    if (pend_full_q) begin
                        // Pending goes to work; a same-cycle
                        // arrival takes the freed slot.
                        load        = 1'b1;
                        load_vec    = pend_q;
                        pend_full_d = valid_i;
                        if (valid_i) begin
                            pend_d = vec_t'(data_i);
                        end
                    end else if (valid_i) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    best_d = best_nxt;
                    idx_d  = idx_nxt;
                    cnt_d  = cnt_q + FIRST;
                    if (valid_i) begin
                        if (pend_full_q) begin
                            drop_d = 1'b1;
                        end else begin
                            pend_d      = vec_t'(data_i);
                            pend_full_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Element 0 seeds the running best; scan starts at 1.
        if (load) begin
            work_d  = load_vec;
            best_d  = load_vec[0];
            idx_d   = '0;
            cnt_d   = FIRST;
            state_d = SCAN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            work_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            best_q      <= '0;
            class_q     <= '0;
            max_q       <= '0;
            valid_q     <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            class_q     <= class_d;
            max_q       <= max_d;
            valid_q     <= valid_d;
            drop_q      <= drop_d;
        end
    end

    assign class_o = class_q;
    assign max_o   = max_q;
    assign valid_o = valid_q;
    assign drop_o  = drop_q;
    assign busy_o  = (state_q == SCAN);
    assign pend_o  = pend_full_q;

endmodule

// File: tb/tb_dense_argmax_rx.sv
// Bench for dense_argmax_rx: signed and unsigned instances fed in parallel,
// checked cycle by cycle against a job-level reference model.
module tb_dense_argmax_rx;

    localparam int NC   = 7;
    localparam int VW   = 8 * NC;
    localparam int MAXC = 2048;

    typedef logic [VW-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       valid_i = 1'b0;
    vec_t       data_i = '0;

    logic [2:0] class_s, class_u;
    logic [7:0] max_s, max_u;
    logic       valid_s, valid_u, busy_s, busy_u;
    logic       pend_s, pend_u, drop_s, drop_u;

    always #5 clk = ~clk;

    dense_argmax_rx #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i),
        .class_o(class_s), .max_o(max_s), .valid_o(valid_s),
        .busy_o(busy_s), .pend_o(pend_s), .drop_o(drop_s)
    );

    dense_argmax_rx #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .rstn(rstn), .data_i(data_i), .valid_i(valid_i),
        .class_o(class_u), .max_o(max_u), .valid_o(valid_u),
        .busy_o(busy_u), .pend_o(pend_u), .drop_o(drop_u)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Expected per-cycle flags {valid, drop, busy, pend} and results.
    logic [3:0] ef  [MAXC];
    logic [2:0] ecs [MAXC];
    logic [7:0] ems [MAXC];
    logic [2:0] ecu [MAXC];
    logic [7:0] emu [MAXC];

    int   job_r;
    bit   p_has;
    vec_t p_vec;

    // Observed values for the cycle just stepped.
    int         ot;
    logic [3:0] o_fs, o_fu;
    logic [2:0] o_cs, o_cu;
    logic [7:0] o_ms, o_mu;

    function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6);
        vec_t v;
        v = {8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        return v;
    endfunction

    function automatic void argmax(input vec_t v, input bit sg,
                                   output int ci, output logic [7:0] m);
        logic [7:0] e;
        ci = 0;
        m  = v[7:0];
        for (int k = 1; k < NC; k++) begin
            e = v[8*k +: 8];
            if (sg ? ($signed(e) > $signed(m)) : (e > m)) begin
                ci = k;
                m  = e;
            end
        end
    endfunction

    task automatic model_clear();
        for (int c = 0; c < MAXC; c++) begin
            ef[c]  = '0;
            ecs[c] = '0;
            ems[c] = '0;
            ecu[c] = '0;
            emu[c] = '0;
        end
        job_r = 0;
        p_has = 1'b0;
    endtask

    // A job starting its scan in cycle s reports in cycle s+NC-1.
    task automatic start_job(input int s, input vec_t v);
        int ci;
        logic [7:0] m;
        job_r = s + NC - 1;
        for (int c = s; c < job_r; c++) ef[c][1] = 1'b1;
        ef[job_r][3] = 1'b1;
        argmax(v, 1'b1, ci, m);
        ecs[job_r] = 3'(ci);
        ems[job_r] = m;
        argmax(v, 1'b0, ci, m);
        ecu[job_r] = 3'(ci);
        emu[job_r] = m;
    endtask

    task automatic model_step(input int t, input bit v, input vec_t d);
        bit active;
        active = (job_r != 0) && (t <= job_r - 1);
        if (!active) begin
            if (v) start_job(t + 1, d);
        end else if (t == job_r - 1) begin
            if (p_has) begin
                start_job(t + 1, p_vec);
                if (v) begin
                    p_vec = d;
                    for (int c = t + 1; c < job_r; c++) ef[c][0] = 1'b1;
                end else begin
                    p_has = 1'b0;
                end
            end else if (v) begin
                start_job(t + 1, d);
            end
        end else if (v) begin
            if (!p_has) begin
                p_has = 1'b1;
                p_vec = d;
                for (int c = t + 1; c < job_r; c++) ef[c][0] = 1'b1;
            end else begin
                ef[t + 1][2] = 1'b1;
            end
        end
    endtask

    // Drive one cycle (called just after a rising edge).
    task automatic tick(input bit v, input vec_t d);
        valid_i = v;
        data_i  = d;
        @(negedge clk);
        ot   = cyc;
        o_fs = {valid_s, drop_s, busy_s, pend_s};
        o_fu = {valid_u, drop_u, busy_u, pend_u};
        o_cs = class_s;
        o_ms = max_s;
        o_cu = class_u;
        o_mu = max_u;
        if (rstn) model_step(cyc, v, d);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        #3 rstn = 1'b0;
        #1;
        total++;
        if ({o_fs, class_s, max_s, valid_s, drop_s, busy_s, pend_s,
             class_u, max_u, valid_u, drop_u, busy_u, pend_u} !== '0) begin
            bad++;
            $display("FAIL reset outputs got s=%b/%0d/%0d u=%b/%0d/%0d want 0",
                     {valid_s, drop_s, busy_s, pend_s}, class_s, max_s,
                     {valid_u, drop_u, busy_u, pend_u}, class_u, max_u);
        end
        model_clear();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_tie();
        bit   vq[$];
        vec_t dq[$];
        vq.push_back(1'b1);
        dq.push_back(mk(10, -3, 45, 45, 0, -128, 44));
        repeat (10) begin vq.push_back(1'b0); dq.push_back('0); end
        foreach (vq[i]) begin
            tick(vq[i], dq[i]);
            total++;
            if ({o_fs, o_fu} !== {ef[ot], ef[ot]}) begin
                bad++;
                $display("FAIL tie_flags t=%0d got %b/%b want %b", ot, o_fs, o_fu, ef[ot]);
            end
            if (ef[ot][3]) begin
                total++;
                if ({o_cs, o_ms, o_cu, o_mu} !== {ecs[ot], ems[ot], ecu[ot], emu[ot]}) begin
                    bad++;
                    $display("FAIL tie_res t=%0d got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                             ot, o_cs, o_ms, o_cu, o_mu, ecs[ot], ems[ot], ecu[ot], emu[ot]);
                end
            end
        end
        total++;
        if ({class_s, max_s} !== {3'd2, 8'd45}) begin
            bad++;
            $display("FAIL tie_const got class=%0d max=%0d want class=2 max=45", class_s, max_s);
        end
    endtask

    task automatic test_sign();
        bit   vq[$];
        vec_t dq[$];
        vq.push_back(1'b1);
        dq.push_back(mk(8'h7F, 1, 2, 3, 4, 8'h80, 5));
        repeat (9) begin vq.push_back(1'b0); dq.push_back('0); end
        foreach (vq[i]) begin
            tick(vq[i], dq[i]);
            total++;
            if ({o_fs, o_fu} !== {ef[ot], ef[ot]}) begin
                bad++;
                $display("FAIL sign_flags t=%0d got %b/%b want %b", ot, o_fs, o_fu, ef[ot]);
            end
            if (ef[ot][3]) begin
                total++;
                if ({o_cs, o_ms, o_cu, o_mu} !== {ecs[ot], ems[ot], ecu[ot], emu[ot]}) begin
                    bad++;
                    $display("FAIL sign_res t=%0d got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                             ot, o_cs, o_ms, o_cu, o_mu, ecs[ot], ems[ot], ecu[ot], emu[ot]);
                end
            end
        end
        total++;
        if ({class_s, max_s, class_u, max_u} !== {3'd0, 8'h7F, 3'd5, 8'h80}) begin
            bad++;
            $display("FAIL sign_const got s=%0d/%h u=%0d/%h want s=0/7f u=5/80",
                     class_s, max_s, class_u, max_u);
        end
    endtask

    task automatic test_back_to_back();
        bit   vq[$];
        vec_t dq[$];
        int   t0;
        int   first_drop;
        t0 = cyc;
        first_drop = -1;
        vq.push_back(1'b1); dq.push_back(mk(1, 2, 3, 4, 5, 6, 7));
        vq.push_back(1'b1); dq.push_back(mk(-9, 20, -1, 3, 20, 0, 19));
        vq.push_back(1'b1); dq.push_back(mk(99, 0, 0, 0, 0, 0, 0));
        repeat (14) begin vq.push_back(1'b0); dq.push_back('0); end
        foreach (vq[i]) begin
            tick(vq[i], dq[i]);
            if (o_fs[2] && first_drop < 0) first_drop = ot;
            total++;
            if ({o_fs, o_fu} !== {ef[ot], ef[ot]}) begin
                bad++;
                $display("FAIL b2b_flags t=%0d got %b/%b want %b", ot, o_fs, o_fu, ef[ot]);
            end
            if (ef[ot][3]) begin
                total++;
                if ({o_cs, o_ms, o_cu, o_mu} !== {ecs[ot], ems[ot], ecu[ot], emu[ot]}) begin
                    bad++;
                    $display("FAIL b2b_res t=%0d got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                             ot, o_cs, o_ms, o_cu, o_mu, ecs[ot], ems[ot], ecu[ot], emu[ot]);
                end
            end
        end
        total++;
        if (first_drop !== t0 + 3) begin
            bad++;
            $display("FAIL b2b_drop_cycle got %0d want %0d", first_drop - t0, 3);
        end
    endtask

    task automatic test_final_refill();
        bit   vq[$];
        vec_t dq[$];
        int   drops;
        drops = 0;
        vq.push_back(1'b1); dq.push_back(mk(5, 4, 3, 2, 1, 0, -1));
        vq.push_back(1'b1); dq.push_back(mk(0, 0, 0, 0, 0, 0, 77));
        repeat (4) begin vq.push_back(1'b0); dq.push_back('0); end
        vq.push_back(1'b1); dq.push_back(mk(-5, -4, -3, -2, -1, -6, -7));
        repeat (16) begin vq.push_back(1'b0); dq.push_back('0); end
        foreach (vq[i]) begin
            tick(vq[i], dq[i]);
            if (o_fs[2] || o_fu[2]) drops++;
            total++;
            if ({o_fs, o_fu} !== {ef[ot], ef[ot]}) begin
                bad++;
                $display("FAIL refill_flags t=%0d got %b/%b want %b", ot, o_fs, o_fu, ef[ot]);
            end
            if (ef[ot][3]) begin
                total++;
                if ({o_cs, o_ms, o_cu, o_mu} !== {ecs[ot], ems[ot], ecu[ot], emu[ot]}) begin
                    bad++;
                    $display("FAIL refill_res t=%0d got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                             ot, o_cs, o_ms, o_cu, o_mu, ecs[ot], ems[ot], ecu[ot], emu[ot]);
                end
            end
        end
        total++;
        if (drops !== 0) begin
            bad++;
            $display("FAIL refill_drops got %0d want 0", drops);
        end
    endtask

    task automatic test_reset_mid();
        bit   vq[$];
        vec_t dq[$];
        tick(1'b1, mk(3, 1, 4, 1, 5, 9, 2));
        tick(1'b1, mk(2, 7, 1, 8, 2, 8, 1));
        tick(1'b0, '0);
        rstn = 1'b0;
        #1;
        total++;
        if ({class_s, max_s, valid_s, drop_s, busy_s, pend_s,
             class_u, max_u, valid_u, drop_u, busy_u, pend_u} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got s=%b/%0d/%0d u=%b/%0d/%0d want 0",
                     {valid_s, drop_s, busy_s, pend_s}, class_s, max_s,
                     {valid_u, drop_u, busy_u, pend_u}, class_u, max_u);
        end
        model_clear();
        tick(1'b0, '0);
        tick(1'b0, '0);
        rstn = 1'b1;
        repeat (3) begin vq.push_back(1'b0); dq.push_back('0); end
        vq.push_back(1'b1); dq.push_back(mk(-1, -2, 60, -3, 61, 61, 0));
        repeat (9) begin vq.push_back(1'b0); dq.push_back('0); end
        foreach (vq[i]) begin
            tick(vq[i], dq[i]);
            total++;
            if ({o_fs, o_fu} !== {ef[ot], ef[ot]}) begin
                bad++;
                $display("FAIL midrst_flags t=%0d got %b/%b want %b", ot, o_fs, o_fu, ef[ot]);
            end
            if (ef[ot][3]) begin
                total++;
                if ({o_cs, o_ms, o_cu, o_mu} !== {ecs[ot], ems[ot], ecu[ot], emu[ot]}) begin
                    bad++;
                    $display("FAIL midrst_res t=%0d got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                             ot, o_cs, o_ms, o_cu, o_mu, ecs[ot], ems[ot], ecu[ot], emu[ot]);
                end
            end
        end
    endtask

    task automatic test_all_equal();
        bit   vq[$];
        vec_t dq[$];
        vq.push_back(1'b1);
        dq.push_back(mk(8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0));
        repeat (9) begin vq.push_back(1'b0); dq.push_back('0); end
        foreach (vq[i]) begin
            tick(vq[i], dq[i]);
            total++;
            if ({o_fs, o_fu} !== {ef[ot], ef[ot]}) begin
                bad++;
                $display("FAIL equal_flags t=%0d got %b/%b want %b", ot, o_fs, o_fu, ef[ot]);
            end
        end
        total++;
        if ({class_s, max_s, class_u, max_u} !== {3'd0, 8'hF0, 3'd0, 8'hF0}) begin
            bad++;
            $display("FAIL equal_const got s=%0d/%h u=%0d/%h want 0/f0",
                     class_s, max_s, class_u, max_u);
        end
    endtask

    task automatic test_random();
        vec_t d;
        logic [7:0] b;
        bit v;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NC; k++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 1) == 1) b = {b[7], 7'h10};
                d[8*k +: 8] = b;
            end
            if (n >= 380) v = 1'b0;
            tick(v, d);
            total++;
            if ({o_fs, o_fu} !== {ef[ot], ef[ot]}) begin
                bad++;
                $display("FAIL rand_flags t=%0d got %b/%b want %b", ot, o_fs, o_fu, ef[ot]);
            end
            if (ef[ot][3]) begin
                total++;
                if ({o_cs, o_ms, o_cu, o_mu} !== {ecs[ot], ems[ot], ecu[ot], emu[ot]}) begin
                    bad++;
                    $display("FAIL rand_res t=%0d got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d",
                             ot, o_cs, o_ms, o_cu, o_mu, ecs[ot], ems[ot], ecu[ot], emu[ot]);
                end
            end
        end
    endtask

    initial begin
        o_fs = '0;
        model_clear();
        test_reset();
        test_tie();
        test_sign();
        test_back_to_back();
        test_final_refill();
        test_reset_mid();
        test_all_equal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
